// File: rtl/i2c_master.sv
// i2c_master
// Single-master I2C controller issuing one register access per transaction
// (3-bit register address, 8 data bits) to a fixed 7-bit target address.
// SCL is driven push-pull, SDA is open-drain (drive 0 or release to z).
//
// Parameters:
//   CLK_DIV  : clk cycles per SCL quarter-bit phase (1..1023)
//   DEV_ADDR : 7-bit target address
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : transaction request, sampled only while idle
//   rw       : 0 = register write, 1 = register read
//   reg_addr : target register
//   wdata    : write data
//   busy     : transaction in progress
//   done     : one-cycle pulse at end of transaction
//   ack_err  : last transaction saw a NACK (held until next accepted start)
//   rdata    : last successfully read byte
//   scl      : I2C clock, idle high
//   sda      : I2C data, open-drain, sampled from the pin
module i2c_master #(
  parameter int         CLK_DIV  = 25,
  parameter logic [6:0] DEV_ADDR = 7'h60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic [2:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl,
  inout  wire        sda
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_RSTART, S_RX_BYTE, S_TX_NACK, S_STOP
  } state_t;

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  state_t      state_reg, state_next;
  logic [9:0]  div_reg;
  logic [1:0]  phase_reg;
  logic [2:0]  bit_reg;
  logic [1:0]  byte_reg;
  logic        rw_reg;
  logic [2:0]  addr_reg;
  logic [7:0]  wdata_reg;
  logic [7:0]  rx_reg;
  logic        nack_reg;   // SDA level sampled in the current bit (1 = NACK)
  logic [7:0]  rdata_reg;
  logic        ack_err_reg;
  logic        done_reg;

  logic        accept;
  logic        phase_end;
  logic        bit_end;
  logic        sample_pt;
  logic        sda_in;
  logic        sda_low;
  logic [7:0]  tx_byte;

  assign sda_in    = sda;
  assign accept    = start && (state_reg == S_IDLE);
  assign phase_end = (div_reg == DIV_LAST);
  assign bit_end   = phase_end && (phase_reg == 2'd3);
  // SDA is sampled on the last cycle of P2, while SCL is high.
  assign sample_pt = phase_end && (phase_reg == 2'd2);

  // Byte 2 is the read address on a read and the data byte on a write.
  always_comb begin
    tx_byte = {DEV_ADDR, 1'b0};
    case (byte_reg)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = {5'b0, addr_reg};
      default: tx_byte = rw_reg ? {DEV_ADDR, 1'b1} : wdata_reg;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_START;
      S_START:   if (bit_end) state_next = S_TX_BYTE;
      S_TX_BYTE: if (bit_end && bit_reg == 3'd0) state_next = S_RX_ACK;
      S_RX_ACK: begin
        if (bit_end) begin
          if (nack_reg) begin
            state_next = S_STOP;
          end else begin
            case (byte_reg)
              2'd0:    state_next = S_TX_BYTE;
              2'd1:    state_next = rw_reg ? S_RSTART : S_TX_BYTE;
              default: state_next = rw_reg ? S_RX_BYTE : S_STOP;
            endcase
          end
        end
      end
      S_RSTART:  if (bit_end) state_next = S_TX_BYTE;
      S_RX_BYTE: if (bit_end && bit_reg == 3'd0) state_next = S_TX_NACK;
      S_TX_NACK: if (bit_end) state_next = S_STOP;
      S_STOP:    if (bit_end) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Timing counters and datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg     <= '0;
      phase_reg   <= '0;
      bit_reg     <= 3'd7;
      byte_reg    <= '0;
      rw_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rx_reg      <= '0;
      nack_reg    <= 1'b0;
      rdata_reg   <= '0;
      ack_err_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_STOP) && bit_end;

      if (state_reg == S_IDLE) begin
        div_reg   <= '0;
        phase_reg <= '0;
        bit_reg   <= 3'd7;
      end else if (phase_end) begin
        div_reg   <= '0;
        phase_reg <= phase_reg + 2'd1;
      end else begin
        div_reg <= div_reg + 10'd1;
      end

      // Only the byte states last more than one bit time, so a bit end
      // without a state change is always the next bit of the same byte.
      if (state_reg != S_IDLE && bit_end) begin
        bit_reg <= (state_next == state_reg) ? bit_reg - 3'd1 : 3'd7;
      end

      if (accept) begin
        rw_reg      <= rw;
        addr_reg    <= reg_addr;
        wdata_reg   <= wdata;
        byte_reg    <= '0;
        ack_err_reg <= 1'b0;
      end

      if (sample_pt) begin
        nack_reg <= sda_in;
        if (state_reg == S_RX_BYTE) rx_reg <= {rx_reg[6:0], sda_in};
      end

      if (bit_end && state_reg == S_RX_ACK) begin
        if (nack_reg) ack_err_reg <= 1'b1;
        else if (byte_reg != 2'd2) byte_reg <= byte_reg + 2'd1;
      end

      if (bit_end && state_reg == S_RX_BYTE && bit_reg == 3'd0) begin
        rdata_reg <= rx_reg;
      end
    end
  end

  // Bus outputs
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (state_reg)
      S_IDLE: begin
        scl     = 1'b1;
        sda_low = 1'b0;
      end
      S_START, S_RSTART: begin
        scl     = (phase_reg != 2'd3);
        sda_low = (phase_reg >= 2'd2);
      end
      S_TX_BYTE: begin
        scl     = (phase_reg >= 2'd2);
        sda_low = ~tx_byte[bit_reg];
      end
      S_STOP: begin
        scl     = (phase_reg >= 2'd2);
        sda_low = (phase_reg != 2'd3);
      end
      default: begin
        // ACK, RX data and master NACK slots: SDA released
        scl     = (phase_reg >= 2'd2);
        sda_low = 1'b0;
      end
    endcase
  end

  assign sda     = sda_low ? 1'b0 : 1'bz;
  assign busy    = (state_reg != S_IDLE);
  assign done    = done_reg;
  assign ack_err = ack_err_reg;
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_i2c_master.sv
module tb_i2c_master;

  localparam int         DIV = 2;
  localparam logic [6:0] DEV = 7'h60;
  localparam int EV_START = 256;
  localparam int EV_STOP  = 257;
  localparam int EV_ACK   = 258;
  localparam int EV_NACK  = 259;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [2:0] reg_addr = 3'd0;
  logic [7:0] wdata = 8'd0;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;
  logic       scl;
  wire        sda;

  logic       tgt_drv = 1'b0;
  logic [7:0] ack_mask = 8'hFF;
  logic [7:0] rd_byte = 8'h5C;

  assign sda = tgt_drv ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_master #(.CLK_DIV(DIV), .DEV_ADDR(DEV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .rw       (rw),
    .reg_addr (reg_addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .rdata    (rdata),
    .scl      (scl),
    .sda      (sda)
  );

  // Behavioural target plus bus monitor, polled mid-cycle. Bus events go
  // into log_q: byte values, START, STOP, and the level seen in each ACK slot.
  int         log_q[$];
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  bit         active = 0;
  bit         rd_mode = 0;
  bit         rel_pending = 0;
  int         cnt = 0;
  int         gbyte = 0;
  int         hold = 0;
  logic [7:0] shreg = 8'd0;

  always @(negedge clk) begin
    if (!reset_n) begin
      active = 0; rd_mode = 0; gbyte = 0; hold = 0; tgt_drv = 1'b0; rel_pending = 0;
    end else begin
      if (scl_p && scl && sda_p && !sda) begin
        log_q.push_back(EV_START);
        active = 1;
        cnt = 0;
      end else if (scl_p && scl && !sda_p && sda) begin
        if (rel_pending) begin
          rel_pending = 0;
        end else if (active) begin
          log_q.push_back(EV_STOP);
          active = 0; gbyte = 0; rd_mode = 0;
        end
      end else if (active && !scl_p && scl) begin
        cnt++;
        if (cnt % 9 != 0) begin
          shreg = {shreg[6:0], sda};
          if (cnt % 9 == 8) begin
            log_q.push_back(int'(shreg));
            if (shreg == {DEV, 1'b1}) rd_mode = 1;
            gbyte++;
          end
        end else begin
          log_q.push_back((sda === 1'b0) ? EV_ACK : EV_NACK);
          if (tgt_drv) hold = 3;
        end
      end else if (active && scl_p && !scl) begin
        if (rd_mode && cnt >= 9 && cnt <= 16) tgt_drv = !rd_byte[16 - cnt];
        else if (rd_mode && cnt == 17) tgt_drv = 1'b0;
        else if (cnt % 9 == 8) tgt_drv = ack_mask[gbyte - 1];
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          tgt_drv = 1'b0;
          rel_pending = 1;
        end
      end
    end
    scl_p = scl;
    sda_p = sda;
  end

  int passes = 0;
  int total  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_log(input string tag, input int base, input int exp[$]);
    int n;
    n = log_q.size() - base;
    check({tag, "_len"}, n, exp.size());
    for (int i = 0; i < exp.size() && i < n; i++) begin
      check($sformatf("%s_ev%0d", tag, i), log_q[base + i], exp[i]);
    end
  endtask

  // Called on a negedge; returns on the first negedge with busy high.
  task automatic issue(input logic r, input logic [2:0] a, input logic [7:0] d);
    rw = r; reg_addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    for (int k = 0; k < 2000 && busy === 1'b1; k++) begin
      @(negedge clk);
      if (busy === 1'b1) cyc++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_scl", int'(scl), 1);
    check("rst_sda", int'(sda), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ack_err", int'(ack_err), 0);
    check("rst_rdata", int'(rdata), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write with ACK
    ack_mask = 8'hFF;
    base = log_q.size();
    issue(1'b0, 3'd3, 8'hA5);
    check("wr_busy_rise", int'(busy), 1);
    wait_done(1, cyc);
    check("wr_cycles", cyc, 232);
    check("wr_done", int'(done), 1);
    check("wr_busy_fall", int'(busy), 0);
    check("wr_ack_err", int'(ack_err), 0);
    check_log("wr_bus", base, '{EV_START, 8'hC0, EV_ACK, 8'h03, EV_ACK, 8'hA5, EV_ACK, EV_STOP});
    @(negedge clk);
    check("wr_done_pulse", int'(done), 0);

    // Read
    rd_byte = 8'h5C;
    base = log_q.size();
    issue(1'b1, 3'd7, 8'h00);
    wait_done(1, cyc);
    check("rd_cycles", cyc, 312);
    check("rd_done", int'(done), 1);
    check("rd_ack_err", int'(ack_err), 0);
    check("rd_rdata", int'(rdata), 8'h5C);
    check_log("rd_bus", base, '{EV_START, 8'hC0, EV_ACK, 8'h07, EV_ACK,
                               EV_START, 8'hC1, EV_ACK, 8'h5C, EV_NACK, EV_STOP});
    @(negedge clk);

    // Address NACK
    ack_mask = 8'h00;
    base = log_q.size();
    issue(1'b1, 3'd1, 8'h00);
    wait_done(1, cyc);
    check("an_cycles", cyc, 88);
    check("an_done", int'(done), 1);
    check("an_ack_err", int'(ack_err), 1);
    check("an_rdata", int'(rdata), 8'h5C);
    check_log("an_bus", base, '{EV_START, 8'hC0, EV_NACK, EV_STOP});
    @(negedge clk);

    // Data NACK on write
    ack_mask = 8'h03;
    base = log_q.size();
    issue(1'b0, 3'd6, 8'h3E);
    wait_done(1, cyc);
    check("dn_cycles", cyc, 232);
    check("dn_ack_err", int'(ack_err), 1);
    check_log("dn_bus", base, '{EV_START, 8'hC0, EV_ACK, 8'h06, EV_ACK, 8'h3E, EV_NACK, EV_STOP});
    repeat (3) @(negedge clk);
    check("dn_ack_err_hold", int'(ack_err), 1);
    check("dn_rdata", int'(rdata), 8'h5C);

    // Request handling: start while busy ignored, inputs changed mid-transaction
    ack_mask = 8'hFF;
    base = log_q.size();
    issue(1'b0, 3'd5, 8'h3C);
    check("rq_ack_err_clr", int'(ack_err), 0);
    cyc = 1;
    repeat (40) begin @(negedge clk); cyc++; end
    rw = 1'b1; reg_addr = 3'd0; wdata = 8'hFF; start = 1'b1;
    @(negedge clk); cyc++;
    start = 1'b0;
    wait_done(cyc, cyc);
    check("rq_cycles", cyc, 232);
    check("rq_done", int'(done), 1);
    check_log("rq_bus", base, '{EV_START, 8'hC0, EV_ACK, 8'h05, EV_ACK, 8'h3C, EV_ACK, EV_STOP});

    // Back-to-back start in the done cycle
    base = log_q.size();
    issue(1'b0, 3'd2, 8'h81);
    check("bb_busy", int'(busy), 1);
    repeat (3) @(negedge clk);
    check("bb_sda_pre", int'(sda), 1);
    check("bb_scl_pre", int'(scl), 1);
    @(negedge clk);
    check("bb_sda_start", int'(sda), 0);
    check("bb_scl_start", int'(scl), 1);
    wait_done(5, cyc);
    check("bb_cycles", cyc, 232);
    check_log("bb_bus", base, '{EV_START, 8'hC0, EV_ACK, 8'h02, EV_ACK, 8'h81, EV_ACK, EV_STOP});
    @(negedge clk);

    // Reset mid-byte
    issue(1'b0, 3'd4, 8'h00);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mr_scl", int'(scl), 1);
    check("mr_sda", int'(sda), 1);
    check("mr_busy", int'(busy), 0);
    check("mr_done", int'(done), 0);
    check("mr_rdata", int'(rdata), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    base = log_q.size();
    issue(1'b0, 3'd1, 8'h96);
    wait_done(1, cyc);
    check("mr_wr_cycles", cyc, 232);
    check("mr_wr_done", int'(done), 1);
    check("mr_wr_ack_err", int'(ack_err), 0);
    check_log("mr_bus", base, '{EV_START, 8'hC0, EV_ACK, 8'h01, EV_ACK, 8'h96, EV_ACK, EV_STOP});

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
